// File: rtl/cacheline_adapter.sv
// ----------------------------------------------------------------------------
// cacheline_adapter
//
// Memory-side responder for the cache DFP port. Each request moves one whole
// cache line (BEAT_W*NUM_BEATS bits). The line is split into NUM_BEATS beats
// on the burst-memory (bmem) port. dfp_resp pulses for one cycle when the line
// transfer is done.
//
// Ports
//   clk          clock; all state updates on the rising edge
//   rst          synchronous, active-high reset
//   dfp_addr     line address from the cache (byte offset bits are ignored)
//   dfp_read     line read request, held by the cache until dfp_resp
//   dfp_write    line write request, held by the cache until dfp_resp
//   dfp_wdata    write line; beat i = dfp_wdata[BEAT_W*i +: BEAT_W]
//   dfp_rdata    read line, valid when dfp_resp follows a read
//   dfp_resp     one-cycle completion pulse
//   bmem_addr    line-aligned address of the current transaction
//   bmem_read    burst read command
//   bmem_write   write beat valid
//   bmem_wdata   current write beat
//   bmem_ready   memory accepts the command / beat this cycle
//   bmem_rdata   returned read beat
//   bmem_rvalid  bmem_rdata valid this cycle (beats arrive in order)
// ----------------------------------------------------------------------------
module cacheline_adapter #(
    parameter int BEAT_W    = 64,
    parameter int NUM_BEATS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 dfp_addr,
    input  logic                        dfp_read,
    input  logic                        dfp_write,
    input  logic [BEAT_W*NUM_BEATS-1:0] dfp_wdata,
    output logic [BEAT_W*NUM_BEATS-1:0] dfp_rdata,
    output logic                        dfp_resp,
    output logic [31:0]                 bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid
);

    localparam int LINE_W = BEAT_W * NUM_BEATS;
    localparam int CNT_W  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    // Clears the byte-offset bits so bmem always sees a line-aligned address.
    localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_READ_REQ  = 3'd2,
        S_READ_WAIT = 3'd3,
        S_RESP      = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    state_e                               state_q;
    logic [CNT_W-1:0]                     cnt_q;
    logic [NUM_BEATS-1:0][BEAT_W-1:0]     line_q;
    logic [LINE_W-1:0]                    dfp_rdata_q;
    logic                                 dfp_resp_q;
    logic [31:0]                          bmem_addr_q;
    logic                                 bmem_read_q;
    logic                                 bmem_write_q;
    logic [BEAT_W-1:0]                    bmem_wdata_q;

    logic [NUM_BEATS-1:0][BEAT_W-1:0]     line_merged_s;
    logic [BEAT_W-1:0]                    wbeat_next_d;

    // Line with the incoming read beat already inserted, and the write beat to present after an accept.
    always_comb begin
        line_merged_s        = line_q;
        line_merged_s[cnt_q] = bmem_rdata;
        if (cnt_q == LAST_CNT) begin
            // Final beat: nothing follows, keep the current beat on the bus.
            wbeat_next_d = bmem_wdata_q;
        end else begin
            wbeat_next_d = line_q[cnt_q + CNT_ONE];
        end
    end

    // Transaction FSM; every output is driven from a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            dfp_rdata_q  <= '0;
            dfp_resp_q   <= 1'b0;
            bmem_addr_q  <= 32'd0;
            bmem_read_q  <= 1'b0;
            bmem_write_q <= 1'b0;
            bmem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    // Write has priority if the cache raises both requests.
                    if (dfp_write) begin
                        bmem_addr_q  <= dfp_addr & ADDR_MASK;
                        line_q       <= dfp_wdata;
                        bmem_wdata_q <= dfp_wdata[BEAT_W-1:0];
                        bmem_write_q <= 1'b1;
                        state_q      <= S_WRITE;
                    end else if (dfp_read) begin
                        bmem_addr_q  <= dfp_addr & ADDR_MASK;
                        bmem_read_q  <= 1'b1;
                        state_q      <= S_READ_REQ;
                    end else begin
                        state_q      <= S_IDLE;
                    end
                end

                S_WRITE: begin
                    // With ready low the beat and all outputs simply hold.
                    if (bmem_ready) begin
                        if (cnt_q == LAST_CNT) begin
                            cnt_q        <= '0;
                            bmem_write_q <= 1'b0;
                            dfp_resp_q   <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            cnt_q        <= cnt_q + CNT_ONE;
                            bmem_wdata_q <= wbeat_next_d;
                        end
                    end
                end

                S_READ_REQ: begin
                    if (bmem_ready) begin
                        bmem_read_q <= 1'b0;
                        state_q     <= S_READ_WAIT;
                    end
                end

                S_READ_WAIT: begin
                    if (bmem_rvalid) begin
                        line_q <= line_merged_s;
                        if (cnt_q == LAST_CNT) begin
                            // Publish the merged line so the last beat is not a cycle late.
                            cnt_q       <= '0;
                            dfp_rdata_q <= line_merged_s;
                            dfp_resp_q  <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end

                S_RESP: begin
                    dfp_resp_q <= 1'b0;
                    state_q    <= S_DONE;
                end

                // One dead cycle lets the cache drop its request before IDLE looks again.
                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q      <= S_IDLE;
                    cnt_q        <= '0;
                    dfp_resp_q   <= 1'b0;
                    bmem_read_q  <= 1'b0;
                    bmem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign dfp_rdata  = dfp_rdata_q;
    assign dfp_resp   = dfp_resp_q;
    assign bmem_addr  = bmem_addr_q;
    assign bmem_read  = bmem_read_q;
    assign bmem_write = bmem_write_q;
    assign bmem_wdata = bmem_wdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// ----------------------------------------------------------------------------
// tb_cacheline_adapter
//
// Directed and randomized transactions against cacheline_adapter. The cache
// and the burst memory are both played by the bench. For every transaction
// the expected cycle-by-cycle port values come from the per-cycle ready
// pattern and read-beat gap schedule. Outputs are sampled on the falling edge.
// Inputs are also driven on the falling edge.
// ----------------------------------------------------------------------------
module tb_cacheline_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int           n_checks = 0;
    int           n_fail   = 0;

    // Memory behaviour for the next transaction: ready per cycle (index 1..63)
    // and the number of idle cycles before each read beat.
    bit           rdy_pat [0:63];
    int           gap     [0:3];

    logic [255:0] last_rd_line;
    int           obs_resp_cycle;
    int           resp_count;

    cacheline_adapter #(.BEAT_W(64), .NUM_BEATS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ready_all();
        for (int c = 0; c < 64; c++) rdy_pat[c] = 1'b1;
        for (int j = 0; j < 4; j++) gap[j] = 0;
    endtask

    task automatic set_ready_random();
        for (int c = 0; c < 64; c++) rdy_pat[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
        for (int j = 0; j < 4; j++) gap[j] = $urandom_range(0, 3);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_resp"},   dfp_resp,   1'b0);
        chk({tag, "_bread"},  bmem_read,  1'b0);
        chk({tag, "_bwrite"}, bmem_write, 1'b0);
        chk({tag, "_baddr"},  bmem_addr,  32'd0);
        chk({tag, "_bwdata"}, bmem_wdata, 64'd0);
        chk({tag, "_rdata"},  dfp_rdata,  256'd0);
    endtask

    // One line transfer. Entered at a falling edge with the DUT idle; returns at a
    // falling edge with the DUT idle again. For a read, 'line' is what memory returns.
    task automatic run_txn(input bit is_wr, input bit both, input logic [31:0] addr,
                           input logic [255:0] line, input int hold, input int abort_at);
        int          c4;
        int          rc;
        int          r_cyc;
        int          nrdy;
        int          t [0:3];
        logic [31:0] exp_addr;

        exp_addr = {addr[31:5], 5'd0};
        c4 = 0;
        rc = 0;
        nrdy = 0;
        for (int j = 0; j < 4; j++) t[j] = 0;
        if (is_wr) begin
            // Beats are accepted on the first four ready cycles; resp follows the fourth.
            for (int c = 1; c < 64; c++) begin
                if (rdy_pat[c] && c4 == 0) begin
                    nrdy++;
                    if (nrdy == 4) c4 = c;
                end
            end
            r_cyc = c4 + 1;
        end else begin
            // Command accepted on the first ready cycle; beats follow with the gap schedule.
            for (int c = 1; c < 64; c++) begin
                if (rdy_pat[c] && rc == 0) rc = c;
            end
            t[0] = rc + 1 + gap[0];
            for (int j = 1; j < 4; j++) t[j] = t[j-1] + 1 + gap[j];
            r_cyc = t[3] + 1;
        end

        dfp_addr  = addr;
        dfp_wdata = line;
        dfp_write = is_wr;
        dfp_read  = !is_wr || both;
        resp_count = 0;
        obs_resp_cycle = -1;
        nrdy = 0;

        for (int c = 1; c <= r_cyc + 1; c++) begin
            tick();
            if (abort_at != 0 && c == abort_at) begin
                rst = 1'b1;
                dfp_write = 1'b0;
                dfp_read  = 1'b0;
                bmem_rvalid = 1'b0;
                tick();
                check_all_zero("abort");
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("abort_noresp", dfp_resp, 1'b0);
                    chk("abort_nowrite", bmem_write, 1'b0);
                end
                last_rd_line = '0;
                return;
            end
            if (dfp_resp === 1'b1) begin
                resp_count++;
                obs_resp_cycle = c;
            end
            chk("dfp_resp",   dfp_resp,   c == r_cyc);
            chk("bmem_addr",  bmem_addr,  exp_addr);
            chk("bmem_write", bmem_write, is_wr && c <= c4);
            chk("bmem_read",  bmem_read,  !is_wr && c <= rc);
            if (is_wr && c <= c4) chk("bmem_wdata", bmem_wdata, line[64*nrdy +: 64]);
            chk("dfp_rdata", dfp_rdata, (!is_wr && c >= r_cyc) ? line : last_rd_line);

            bmem_ready = rdy_pat[c];
            if (rdy_pat[c]) nrdy++;
            bmem_rvalid = 1'b0;
            bmem_rdata  = {$urandom, $urandom};
            if (!is_wr) begin
                for (int j = 0; j < 4; j++) begin
                    if (t[j] == c) begin
                        bmem_rvalid = 1'b1;
                        bmem_rdata  = line[64*j +: 64];
                    end
                end
                // Stray beats while the DUT is not waiting for data must be ignored.
                if (c <= rc || c >= r_cyc) bmem_rvalid = ($urandom_range(0, 1) == 1);
            end
            if (c == r_cyc + hold) begin
                dfp_write = 1'b0;
                dfp_read  = 1'b0;
            end
        end
        dfp_write = 1'b0;
        dfp_read  = 1'b0;
        bmem_rvalid = 1'b0;
        tick();
        chk("resp_once",   resp_count, 1);
        chk("idle_resp",   dfp_resp,   1'b0);
        chk("idle_bwrite", bmem_write, 1'b0);
        chk("idle_bread",  bmem_read,  1'b0);
        if (!is_wr) last_rd_line = line;
    endtask

    initial begin
        logic [255:0] ln;
        logic [31:0]  ad;

        rst = 1'b1;
        dfp_addr = 32'd0;
        dfp_read = 1'b0;
        dfp_write = 1'b0;
        dfp_wdata = '0;
        bmem_ready = 1'b0;
        bmem_rdata = 64'd0;
        bmem_rvalid = 1'b0;
        last_rd_line = '0;
        set_ready_all();
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // T1: write, memory always ready.
        for (int i = 0; i < 4; i++) ln[64*i +: 64] = 64'hAAAA_AAAA_AAAA_AA00 | 64'(i);
        set_ready_all();
        run_txn(1'b1, 1'b0, 32'h1234_5678, ln, 0, 0);
        chk("t1_resp_cycle", obs_resp_cycle, 5);

        // T2: read, first beat returned well after the command.
        for (int i = 0; i < 4; i++) ln[64*i +: 64] = 64'(i);
        set_ready_all();
        gap[0] = 9;
        run_txn(1'b0, 1'b0, 32'h0000_0040, ln, 0, 0);
        chk("t2_rdata_hold", dfp_rdata, ln);

        // T3: ready low for three cycles after beat 1 is accepted.
        for (int i = 0; i < 4; i++) ln[64*i +: 64] = {$urandom, $urandom};
        set_ready_all();
        rdy_pat[3] = 1'b0;
        rdy_pat[4] = 1'b0;
        rdy_pat[5] = 1'b0;
        run_txn(1'b1, 1'b0, 32'hCAFE_0123, ln, 0, 0);
        chk("t3_resp_cycle", obs_resp_cycle, 8);

        // T4: stray rvalid while idle, then a read with gapped beats.
        for (int k = 0; k < 3; k++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = {$urandom, $urandom};
            tick();
            chk("t4_idle_rdata", dfp_rdata, last_rd_line);
            chk("t4_idle_resp",  dfp_resp,  1'b0);
        end
        bmem_rvalid = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
        set_ready_all();
        gap[0] = 0;
        gap[1] = 2;
        gap[2] = 5;
        gap[3] = 1;
        run_txn(1'b0, 1'b0, 32'h8000_1FFF, ln, 0, 0);

        // T5: reset after two write beats, then a normal read.
        for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
        set_ready_all();
        run_txn(1'b1, 1'b0, 32'h0BAD_F00D, ln, 0, 3);
        for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
        set_ready_all();
        run_txn(1'b0, 1'b0, 32'h0000_1000, ln, 0, 0);

        // T6: read held one cycle past resp, then read+write together (write wins).
        for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
        set_ready_all();
        run_txn(1'b0, 1'b0, 32'h0000_2020, ln, 1, 0);
        for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
        set_ready_all();
        run_txn(1'b1, 1'b1, 32'h0000_3030, ln, 1, 0);

        // Randomized transactions with random ready and gap patterns.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 8; i++) ln[32*i +: 32] = $urandom;
            ad = $urandom;
            set_ready_random();
            run_txn($urandom_range(0, 1) == 1, 1'b0, ad, ln, $urandom_range(0, 1), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
